ysyx_23060278_ifu: RTL and testbench

Instruction fetch unit: the consumer of the PC register's pc/pc_wen interface. It reads the current pc and issues a word read to the instruction memory over a valid/ready request and a valid-only response. It then holds the fetched instruction for the decoder until the decoder accepts it. On acceptance it pulses pc_wen so the PC register advances to its computed next pc.

---
 rtl/ysyx_23060278_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_23060278_ifu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: reads pc, fetches one word from imem, holds it for the decoder,
// and pulses pc_wen when the decoder accepts it.
module ysyx_23060278_ifu #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_wen,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [63:0] inst_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  localparam logic [16:0] TimeoutCnt = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] inst_cnt_q, inst_cnt_d;
  logic [16:0] cnt_inc;

  assign cnt_inc       = {1'b0, cnt_q} + 17'd1;
  assign imem_req_addr = pc;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign fault         = fault_q;
  assign inst_cnt      = inst_cnt_q;

  always_comb begin
    state_d        = state_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    fault_d        = fault_q;
    cnt_d          = cnt_q;
    inst_cnt_d     = inst_cnt_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    pc_wen         = 1'b0;
    case (state_q)
      // One bubble so pc settles after reset or after pc_wen.
      StIdle: state_d = StReq;
      StReq: begin
        if (pc[1:0] != 2'b00) begin
          inst_d    = NOP_INST;
          inst_pc_d = pc;
          fault_d   = 1'b1;
          state_d   = StHold;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            inst_pc_d = pc;
            cnt_d     = '0;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        // A response arriving on the timeout cycle takes priority.
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
          fault_d = imem_rsp_err;
          state_d = StHold;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (cnt_inc == TimeoutCnt) begin
            inst_d  = NOP_INST;
            fault_d = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_wen     = 1'b1;
          inst_cnt_d = inst_cnt_q + 64'd1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      inst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Scoreboard bench for the fetch unit: stimulus queues expected instructions, a monitor
// pops and compares them on each decoder handshake.
module tb_ysyx_23060278_ifu;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic [31:0] pc;
  logic        pc_wen;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fault;
  logic [63:0] inst_cnt;

  logic        mem_rsp, stale_rsp, mem_mute, mem_err;
  logic [31:0] mem_data;

  assign imem_rsp_valid = mem_rsp | stale_rsp;
  assign imem_rsp_data  = mem_data;
  assign imem_rsp_err   = mem_err;

  ysyx_23060278_ifu #(.TIMEOUT(TO), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_wen         (pc_wen),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .inst_cnt       (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nacc   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Memory: one-cycle response after each accepted request.
  initial begin
    mem_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready && !mem_mute) begin
        @(posedge clk); #1;
        mem_rsp = 1'b1;
        @(posedge clk); #1;
        mem_rsp = 1'b0;
      end
    end
  end

  // Monitor: checks pc_wen every cycle and scores each accepted instruction.
  initial begin
    logic [63:0] mcnt;
    exp_t e;
    mcnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = '0;
      end else begin
        chk("pc_wen", {63'd0, pc_wen}, {63'd0, inst_valid && inst_ready});
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_inst", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("inst", {32'd0, inst}, {32'd0, e.inst});
            chk("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
            chk("fault", {63'd0, fault}, {63'd0, e.fault});
            chk("inst_cnt_pre", inst_cnt, mcnt);
          end
          mcnt = mcnt + 64'd1;
        end
      end
    end
  end

  // Starts in IDLE at posedge+1; returns in IDLE at posedge+1 after acceptance.
  task automatic fetch(input logic [31:0] p, input logic [31:0] d, input logic e,
                       input logic mute, input int rdly, input int hdly, input int lat,
                       input logic [31:0] xi, input logic xf);
    int n;
    logic got;
    logic [31:0] s_inst, s_pc;
    pc = p; mem_data = d; mem_err = e; mem_mute = mute;
    imem_req_ready = (rdly == 0); inst_ready = 1'b0;
    exp_q.push_back({xi, p, xf});
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      chk("req_valid_held", {63'd0, imem_req_valid}, 64'd1);
      chk("req_addr_held", {32'd0, imem_req_addr}, {32'd0, p});
    end
    imem_req_ready = 1'b1;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && rdly == 0) begin
        chk("req_valid", {63'd0, imem_req_valid}, {63'd0, p[1:0] == 2'b00});
        chk("req_addr", {32'd0, imem_req_addr}, {32'd0, p});
      end
      got = inst_valid;
    end
    if (!got) chk("inst_valid_timeout", {63'd0, got}, 64'd1);
    else if (lat >= 0) chk("latency", 64'(n), 64'(lat));
    s_inst = inst; s_pc = inst_pc;
    for (int i = 0; i < hdly; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_inst", {32'd0, inst}, {32'd0, s_inst});
      chk("hold_pc", {32'd0, inst_pc}, {32'd0, s_pc});
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    nacc++;
    chk("idle_after_accept", {63'd0, inst_valid}, 64'd0);
    chk("inst_cnt", inst_cnt, 64'(nacc));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_pc_wen"}, {63'd0, pc_wen}, 64'd0);
    chk({tag, "_inst"}, {32'd0, inst}, 64'd0);
    chk({tag, "_inst_pc"}, {32'd0, inst_pc}, 64'd0);
    chk({tag, "_fault"}, {63'd0, fault}, 64'd0);
    chk({tag, "_inst_cnt"}, inst_cnt, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = 32'h8000_0000; imem_req_ready = 1'b0; inst_ready = 1'b0;
    stale_rsp = 1'b0; mem_mute = 1'b0; mem_err = 1'b0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0, 0, 0, 3, 32'h0010_0093, 1'b0);
    fetch(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b0, 3, 0, -1, 32'h0020_0113, 1'b0);
    fetch(32'h8000_0008, 32'h0030_0193, 1'b0, 1'b0, 0, 5, 3, 32'h0030_0193, 1'b0);
    fetch(32'h8000_000c, 32'hdead_beef, 1'b1, 1'b0, 0, 0, 3, NOP, 1'b1);
    fetch(32'h8000_0010, 32'h0040_0213, 1'b0, 1'b0, 0, 0, 3, 32'h0040_0213, 1'b0);
    fetch(32'h8000_0002, 32'h1234_5678, 1'b0, 1'b0, 0, 0, 2, NOP, 1'b1);
    // Silent memory: 4 WAIT cycles then timeout fault.
    fetch(32'h8000_0014, 32'h0050_0293, 1'b0, 1'b1, 0, 0, 6, NOP, 1'b1);

    // Reset while waiting for a response that never comes.
    pc = 32'h8000_0018; mem_mute = 1'b1; imem_req_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("in_wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("in_wait_inst_valid", {63'd0, inst_valid}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0; nacc = 0; imem_req_ready = 1'b0;
    stale_rsp = 1'b1; mem_data = 32'h0bad_0bad; mem_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stale_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("stale_req_valid", {63'd0, imem_req_valid}, 64'd1);
    end
    stale_rsp = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0, 0, 0, 3, 32'h0010_0093, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
